// File: rtl/mem_responder.sv
// mem_responder: arbitrates the byte-wide RAM port between the load/store
// buffer (single-byte grants) and instruction fetch (4-byte little-endian
// burst). The load/store buffer has priority whenever the address bus is free.
module mem_responder #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_HI      = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  control_hazard,
  input  logic                  io_buffer_full,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_done,
  output logic [31:0]           fetch_inst,
  input  logic                  slb_access_control,
  input  logic [ADDR_WIDTH-1:0] slb_mem_addr,
  input  logic [7:0]            slb_mem_dout,
  input  logic                  slb_mem_wr,
  output logic                  slb_access_valid,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F0    = 3'd1,
    F1    = 3'd2,
    F2    = 3'd3,
    F3    = 3'd4,
    FTAIL = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           fetch_inst_q, fetch_inst_d;
  logic                  fetch_done_q, fetch_done_d;
  // A burst read was issued last cycle, so mem_din carries a fetch byte now.
  // RAM returns data whether or not rdy_in is high, so the byte is taken on
  // arrival; otherwise a freeze right after a read would lose it.
  logic                  rd_pend_q, rd_pend_d;

  logic                  io_stall;
  logic                  grant;
  logic                  accept;
  logic                  flush;
  state_t                cur_state;
  logic [ADDR_WIDTH-1:0] cur_base;

  // Arbitration: grant, fetch acceptance, and the effective state this cycle.
  // An accepted fetch occupies the bus in its acceptance cycle, which is F0.
  always_comb begin
    io_stall  = (slb_mem_addr[17:16] == IO_HI) && io_buffer_full;
    grant     = rdy_in && rst_in && slb_access_control && !io_stall &&
                (state_q == IDLE || state_q == FTAIL);
    accept    = rdy_in && rst_in && (state_q == IDLE) && fetch_req && !grant;
    flush     = control_hazard && (state_q != IDLE);
    cur_state = accept ? F0 : state_q;
    cur_base  = accept ? fetch_addr : base_q;
  end

  // Next-state logic; rdy_in low freezes the burst at its current byte.
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      if (flush) begin
        state_d = IDLE;
      end else begin
        case (cur_state)
          F0:      state_d = F1;
          F1:      state_d = F2;
          F2:      state_d = F3;
          F3:      state_d = FTAIL;
          FTAIL:   state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Bus outputs: SLB grant passes its request through, a burst presents base+k.
  always_comb begin
    mem_a    = '0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    if (rst_in) begin
      if (grant) begin
        mem_a    = slb_mem_addr;
        mem_dout = slb_mem_dout;
        mem_wr   = slb_mem_wr;
      end else begin
        case (cur_state)
          F0:      mem_a = cur_base;
          F1:      mem_a = cur_base + ADDR_WIDTH'(1);
          F2:      mem_a = cur_base + ADDR_WIDTH'(2);
          F3:      mem_a = cur_base + ADDR_WIDTH'(3);
          default: mem_a = '0;
        endcase
      end
    end
  end

  // Byte capture, base latch, completion pulse and read-pending tracking.
  always_comb begin
    fetch_inst_d = fetch_inst_q;
    base_d       = accept ? fetch_addr : base_q;
    fetch_done_d = fetch_done_q;
    rd_pend_d    = rdy_in && !flush &&
                   (cur_state == F0 || cur_state == F1 ||
                    cur_state == F2 || cur_state == F3);
    if (rd_pend_q) begin
      case (state_q)
        F1:      fetch_inst_d[7:0]   = mem_din;
        F2:      fetch_inst_d[15:8]  = mem_din;
        F3:      fetch_inst_d[23:16] = mem_din;
        FTAIL:   fetch_inst_d[31:24] = mem_din;
        default: fetch_inst_d = fetch_inst_q;
      endcase
    end
    if (rdy_in) begin
      fetch_done_d = (state_q == FTAIL) && !control_hazard;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      base_q       <= '0;
      fetch_inst_q <= 32'h0;
      fetch_done_q <= 1'b0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      fetch_inst_q <= fetch_inst_d;
      fetch_done_q <= fetch_done_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  assign fetch_done       = fetch_done_q;
  assign fetch_inst       = fetch_inst_q;
  assign slb_access_valid = grant;

endmodule
